// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 win every contention.
module alu_arbiter #(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned WIDTH   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   output logic [2:0]       rsp0_flags,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic [2:0]       rsp1_flags,
   output logic [WIDTH-1:0] alu_inp1,
   output logic [WIDTH-1:0] alu_inp2,
   output logic [3:0]       alu_operation,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   input  logic             alu_zero,
   input  logic             alu_sign,
   output logic             busy,
   output logic             grant_id
);

   // state | meaning
   // IDLE  | waiting for a request; arbitration winner sees req_ready
   // EXEC  | latched operands on the ALU, counting down ALU_LAT cycles
   // RESP  | captured result presented on rsp[grant_id] until accepted
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_grant;
   logic [WIDTH-1:0] r_data;
   logic [2:0]       r_flags;

   logic w_win;
   logic w_any;
   logic w_accept;
   logic w_capture;
   logic w_done;
   logic w_rsp_ready;

   assign w_any       = req0_valid | req1_valid;
   assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_win = ~req0_valid & req1_valid;
`else
   logic r_last_grant;

   always_comb begin
      w_win = req1_valid;
      if (req0_valid && req1_valid) begin
         w_win = ~r_last_grant;
      end
   end

   // Reset to 1 so port 0 wins the first contention.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_grant <= 1'b1;
      end else if (w_done) begin
         r_last_grant <= r_grant;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_done       = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_accept     = 1'b1;
               req0_ready   = ~w_win;
               req1_ready   = w_win;
               w_next_state = EXEC;
            end
         end
         EXEC: begin
            if (r_cnt == 4'd1) begin
               w_capture    = 1'b1;
               w_next_state = RESP;
            end
         end
         RESP: begin
            if (w_rsp_ready) begin
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= 4'd0;
         r_op    <= 4'd0;
         r_a     <= '0;
         r_b     <= '0;
         r_grant <= 1'b0;
         r_data  <= '0;
         r_flags <= 3'd0;
      end else begin
         if (w_accept) begin
            r_cnt   <= LAT_INIT;
            r_grant <= w_win;
            r_op    <= w_win ? req1_op : req0_op;
            r_a     <= w_win ? req1_a  : req0_a;
            r_b     <= w_win ? req1_b  : req0_b;
         end else if (r_state == EXEC) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_data  <= alu_out;
            r_flags <= {alu_carry, alu_zero, alu_sign};
         end
      end
   end

   assign alu_inp1      = r_a;
   assign alu_inp2      = r_b;
   assign alu_operation = r_op;

   assign rsp0_valid = (r_state == RESP) && !r_grant;
   assign rsp1_valid = (r_state == RESP) &&  r_grant;
   assign rsp0_data  = r_data;
   assign rsp1_data  = r_data;
   assign rsp0_flags = r_flags;
   assign rsp1_flags = r_flags;

   assign busy     = (r_state != IDLE);
   assign grant_id = r_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one ALU_LAT=1 instance and one ALU_LAT=3 instance.
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // ALU_LAT=1 instance signals
   logic        reset;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a, req0_b, rsp0_data;
   logic [2:0]  rsp0_flags;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a, req1_b, rsp1_data;
   logic [2:0]  rsp1_flags;
   logic [31:0] alu_inp1, alu_inp2, alu_out;
   logic [3:0]  alu_operation;
   logic        alu_carry, alu_zero, alu_sign, busy, grant_id;

   // ALU_LAT=3 instance signals
   logic        b_req0_valid, b_req0_ready, b_rsp0_valid, b_rsp0_ready;
   logic [3:0]  b_req0_op;
   logic [31:0] b_req0_a, b_req0_b, b_rsp0_data;
   logic [2:0]  b_rsp0_flags;
   logic        b_req1_valid, b_req1_ready, b_rsp1_valid, b_rsp1_ready;
   logic [3:0]  b_req1_op;
   logic [31:0] b_req1_a, b_req1_b, b_rsp1_data;
   logic [2:0]  b_rsp1_flags;
   logic [31:0] b_alu_inp1, b_alu_inp2, b_alu_out;
   logic [3:0]  b_alu_operation;
   logic        b_alu_carry, b_alu_zero, b_alu_sign, b_busy, b_grant_id;

   // Behavioural stand-in for the KGP-RISC ALU: returns {carry, zero, sign, out}.
   function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      c = 1'b0;
      s = '0;
      case (op)
         4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
         4'h1: r = a & b;
         4'h2: r = a ^ b;
         4'h7: r = $signed(a) >>> b[4:0];
         4'hF: return {3'b101, 32'hDEADBEEF};
         default: r = a | b;
      endcase
      return {c, (r == 32'd0), r[31], r};
   endfunction

   always_comb {alu_carry, alu_zero, alu_sign, alu_out} = alu_f(alu_operation, alu_inp1, alu_inp2);
   always_comb {b_alu_carry, b_alu_zero, b_alu_sign, b_alu_out} =
      alu_f(b_alu_operation, b_alu_inp1, b_alu_inp2);

   alu_arbiter #(.ALU_LAT(1), .WIDTH(32)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp0_flags(rsp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .rsp1_flags(rsp1_flags),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_operation(alu_operation),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
      .busy(busy), .grant_id(grant_id)
   );

   alu_arbiter #(.ALU_LAT(3), .WIDTH(32)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
      .req0_a(b_req0_a), .req0_b(b_req0_b),
      .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_data(b_rsp0_data),
      .rsp0_flags(b_rsp0_flags),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
      .req1_a(b_req1_a), .req1_b(b_req1_b),
      .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_data(b_rsp1_data),
      .rsp1_flags(b_rsp1_flags),
      .alu_inp1(b_alu_inp1), .alu_inp2(b_alu_inp2), .alu_operation(b_alu_operation),
      .alu_out(b_alu_out), .alu_carry(b_alu_carry), .alu_zero(b_alu_zero),
      .alu_sign(b_alu_sign),
      .busy(b_busy), .grant_id(b_grant_id)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] exp_grants;
   int         waited;
   logic       won;

   initial begin
      reset = 1'b0;
      {req0_valid, rsp0_ready, req1_valid, rsp1_ready} = '0;
      req0_op = '0; req0_a = '0; req0_b = '0;
      req1_op = '0; req1_a = '0; req1_b = '0;
      {b_req0_valid, b_rsp0_ready, b_req1_valid, b_rsp1_ready} = '0;
      b_req0_op = '0; b_req0_a = '0; b_req0_b = '0;
      b_req1_op = '0; b_req1_a = '0; b_req1_b = '0;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_outs", {rsp0_valid, rsp1_valid, req0_ready, req1_ready, grant_id}, 0);
      chk("rst_alu", {alu_inp1, alu_inp2}, 0);

      // single add: FFFFFFFF + 1
      req0_valid = 1; req0_op = 4'h0; req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
      #1;
      chk("add_ready", {req0_ready, req1_ready}, 2'b10);
      tick();
      req0_valid = 0;
      #1;
      chk("add_ready_pulse", req0_ready, 0);
      chk("add_busy", busy, 1);
      chk("add_alu_in", {alu_inp1, alu_inp2}, {32'hFFFFFFFF, 32'd1});
      chk("add_no_rsp_yet", rsp0_valid, 0);
      tick();
      chk("add_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b10);
      chk("add_rsp_data", rsp0_data, 32'd0);
      chk("add_rsp_flags", rsp0_flags, 3'b110);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      chk("add_done", {rsp0_valid, busy}, 0);
      chk("add_inp_held", alu_inp1, 32'hFFFFFFFF);

      // reset in the middle of a pending port-1 response
      req1_valid = 1; req1_op = 4'h2; req1_a = 32'd3; req1_b = 32'd5;
      tick();
      req1_valid = 0;
      tick();
      chk("mid_rsp_pending", rsp1_valid, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_outs", {rsp0_valid, rsp1_valid, busy, grant_id}, 0);
      chk("mid_rst_regs", {alu_inp1, alu_inp2, rsp1_data}, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_no_rsp", {rsp1_valid, busy}, 0);

      // simultaneous: port 0 AND wins after reset, port 1 XOR waits
      req0_valid = 1; req0_op = 4'h1; req0_a = 32'd105; req0_b = 32'd110;
      req1_valid = 1; req1_op = 4'h2; req1_a = 32'd105; req1_b = 32'd110;
      #1;
      chk("sim_first_grant", {req0_ready, req1_ready}, 2'b10);
      tick();
      req0_valid = 0;
      rsp1_ready = 1;
      #1;
      chk("sim_grant_id0", grant_id, 0);
      chk("sim_exec_no_ready", req1_ready, 0);
      tick();
      chk("sim_rsp0_data", rsp0_data, 32'd104);
      // backpressure: port 0 response held, stray rsp1_ready ignored
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp0", {rsp0_valid, rsp0_data}, {1'b1, 32'd104});
         chk("bp_hold", {rsp1_valid, req1_ready, busy}, 3'b001);
         tick();
      end
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      chk("bp_port1_accept", req1_ready, 1);
      tick();
      req1_valid = 0;
      rsp1_ready = 0;
      chk("sim_grant_id1", grant_id, 1);
      tick();
      chk("sim_rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
      chk("sim_rsp1_data", {rsp1_flags, rsp1_data}, {3'b000, 32'd7});
      rsp1_ready = 1;
      tick();
      rsp1_ready = 0;
      chk("sim_done", busy, 0);

      // fairness, both ports always valid, responses accepted immediately
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_grants = 4'b0000;
`else
      exp_grants = 4'b1010;
`endif
      req0_valid = 1; req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd2;
      req1_valid = 1; req1_op = 4'h0; req1_a = 32'd3; req1_b = 32'd4;
      rsp0_ready = 1; rsp1_ready = 1;
      #1;
      for (int op = 0; op < 4; op++) begin
         waited = 0;
         while (!(req0_ready || req1_ready) && waited < 10) begin
            tick();
            waited++;
         end
         chk("fair_ready_seen", req0_ready | req1_ready, 1);
         if (op > 0) chk("fair_spacing", waited, 2);
         won = req1_ready;
         chk("fair_grant", won, exp_grants[op]);
         tick();
         chk("fair_grant_id", grant_id, exp_grants[op]);
      end
      req0_valid = 0; req1_valid = 0;
      tick(); tick();
      rsp0_ready = 0; rsp1_ready = 0;
      chk("fair_idle", busy, 0);

      // undefined opcode passthrough, and a request withdrawn before ready
      req0_valid = 1; req0_op = 4'hF; req0_a = 32'd9; req0_b = 32'd9;
      tick();
      req0_valid = 0;
      tick();
      chk("undef_op", alu_operation, 4'hF);
      chk("undef_rsp", {rsp0_valid, rsp0_flags, rsp0_data}, {1'b1, 3'b101, 32'hDEADBEEF});
      req1_valid = 1;
      tick();
      req1_valid = 0;
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      tick();
      chk("withdrawn_not_taken", {busy, req1_ready}, 0);

      // latency 3 instance: arithmetic shift of -105
      b_req1_valid = 1; b_req1_op = 4'h7; b_req1_a = 32'hFFFFFF97; b_req1_b = 32'd1;
      #1;
      chk("lat_ready", b_req1_ready, 1);
      tick();
      b_req1_valid = 0;
      for (int j = 1; j < 3; j++) begin
         tick();
         chk("lat_wait", {b_rsp1_valid, b_busy}, 2'b01);
      end
      tick();
      chk("lat_rsp_valid", {b_rsp0_valid, b_rsp1_valid}, 2'b01);
      chk("lat_rsp_data", {b_rsp1_flags, b_rsp1_data}, {3'b001, 32'hFFFFFFCB});
      b_rsp1_ready = 1;
      tick();
      b_rsp1_ready = 0;
      chk("lat_done", {b_rsp1_valid, b_busy}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single KGP-RISC ALU between two requesters, e.g. the execute stage (port 0) and the branch/compare unit (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, latches operands, drives the ALU for ALU_LAT cycles, then captures the result and flags and holds them until the response is accepted.
- Only one operation is in flight at a time.

Parameters:
- ALU_LAT, 1: ALU result latency in cycles. Legal range 1..15; 4-bit counter.
- WIDTH, 32: operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  4  ALU operation code for port 0.
- req0_a  in  WIDTH  operand 1 for port 0.
- req0_b  in  WIDTH  operand 2 for port 0.
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 result consumed.
- rsp0_data  out  WIDTH  port 0 result.
- rsp0_flags  out  3  port 0 flags {carry, zero, sign}.
- req1_*, rsp1_*  same as port 0, for port 1.
- alu_inp1  out  WIDTH  to ALU inp1.
- alu_inp2  out  WIDTH  to ALU inp2.
- alu_operation  out  4  to ALU operation.
- alu_out  in  WIDTH  from ALU out.
- alu_carry  in  1  from ALU carryFlag.
- alu_zero  in  1  from ALU zeroFlag.
- alu_sign  in  1  from ALU signFlag.
- busy  out  1  state != IDLE.
- grant_id  out  1  requester currently owning the ALU.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; latched operands/op 0; counter 0.
  - last_grant=1, so port 0 wins the first contention.
  - Any in-flight op or pending response is dropped silently.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only for the arbitration winner, only in IDLE.
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - On the accepting edge: latch op/a/b, set grant_id, counter=ALU_LAT, go to EXEC.
  - Dropping valid before ready is legal; nothing is accepted.
- EXEC:
  - alu_inp1/alu_inp2/alu_operation are driven from the latched registers. They are held stable at the last latched values in every state.
  - Counter decrements each cycle.
  - On the edge where counter==1: capture alu_out and {alu_carry, alu_zero, alu_sign} into the result registers and go to RESP.
  - EXEC lasts exactly ALU_LAT cycles.
- RESP:
  - rsp[grant_id]_valid=1 with the captured data/flags; the other port's rsp_valid=0.
  - Held stable until rsp_ready=1 at a rising edge. Then: rsp_valid deasserts, last_grant=grant_id, go to IDLE.
  - No request is accepted in RESP or EXEC; both req_ready=0.
- Latency: accept at edge k; rspN_valid visible after edge k+ALU_LAT.
- Throughput: at most one op per ALU_LAT+2 cycles.
- Op codes are not decoded. Undefined codes (>4'b1000) are passed through, and the ALU result/flags are returned unchanged.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset mid-EXEC or mid-RESP: immediate return to IDLE; no response is ever produced for that op.
- Data and flags are registered outputs; they retain their last value outside RESP but are only meaningful while valid.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both ports are valid. last_grant is unused, and port 1 may starve.
- Undefined: round-robin as described above.

Test Plan:
- Reset: assert reset=0 mid-stream -> all outputs 0, busy=0, state IDLE; after release, the first simultaneous request is granted to port 0.
- Single port-0 add: op=0000, a=32'hFFFFFFFF, b=1, ALU_LAT=1 ->
  - req0_ready pulses 1 cycle.
  - alu_inp1=FFFFFFFF, alu_inp2=1.
  - rsp0_valid one edge later with data=0, flags carry=1 zero=1 sign=0.
- Simultaneous requests: port 0 AND (105,110, op 0001) and port 1 XOR (105,110, op 0010) ->
  - Port 0 is served first, rsp0_data=104.
  - Then port 1, rsp1_data=7.
  - rsp1_valid is never high while rsp0_valid is high.
- Backpressure: hold rsp0_ready=0 for 5 cycles while req1_valid=1 ->
  - rsp0_valid/data stay stable.
  - req1_ready=0 and busy=1 throughout.
  - Port 1 is accepted in the first IDLE cycle after the rsp0 handshake.
- Fairness: both ports held valid with immediate rsp_ready for 4 ops -> grants 0,1,0,1.
  - With ALU_ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0.
- Latency: ALU_LAT=3, port 1 op 0111 with a=-105 -> rsp1_valid exactly 3 edges after acceptance, with ALU result/flags forwarded unmodified.
